// File: rtl/enclave_cmd_dispatcher_if.sv
// Host command, controller configure/done and response bundle
// for the enclave command dispatcher.
interface enclave_cmd_dispatcher_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int TAG_WIDTH  = 4,
    parameter int CNT_WIDTH  = 3
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_opcode;
    logic [ADDR_WIDTH-1:0] cmd_op1_addr;
    logic [ADDR_WIDTH-1:0] cmd_op2_addr;
    logic [ADDR_WIDTH-1:0] cmd_out_addr;
    logic [TAG_WIDTH-1:0]  cmd_tag;

    logic                  ctrl_config_en;
    logic [1:0]            ctrl_opcode;
    logic [ADDR_WIDTH-1:0] ctrl_op1_base_addr;
    logic [ADDR_WIDTH-1:0] ctrl_op2_base_addr;
    logic [ADDR_WIDTH-1:0] ctrl_out_base_addr;
    logic                  ctrl_done;

    logic                  rsp_valid;
    logic [TAG_WIDTH-1:0]  rsp_tag;
    logic                  rsp_timeout;

    logic                  busy;
    logic [CNT_WIDTH-1:0]  queue_count;
    logic                  timeout_err;
    logic                  clear_err;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_op1_addr,
        input  cmd_op2_addr, cmd_out_addr, cmd_tag,
        output cmd_ready,
        output ctrl_config_en, ctrl_opcode,
        output ctrl_op1_base_addr, ctrl_op2_base_addr,
        output ctrl_out_base_addr,
        input  ctrl_done,
        output rsp_valid, rsp_tag, rsp_timeout,
        output busy, queue_count, timeout_err,
        input  clear_err
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_op1_addr,
        output cmd_op2_addr, cmd_out_addr, cmd_tag,
        input  cmd_ready,
        input  ctrl_config_en, ctrl_opcode,
        input  ctrl_op1_base_addr, ctrl_op2_base_addr,
        input  ctrl_out_base_addr,
        output ctrl_done,
        input  rsp_valid, rsp_tag, rsp_timeout,
        input  busy, queue_count, timeout_err,
        output clear_err
    );
endinterface

// File: rtl/enclave_cmd_dispatcher.sv
// Queues host commands and issues them one at a time to the
// enclave controller, reporting completion or timeout per tag.
module enclave_cmd_dispatcher #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TAG_WIDTH      = 4,
    parameter int DEPTH          = 4,
    parameter int CNT_WIDTH      = 3,
    parameter int TIMER_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic clk,
    input logic rst_n,
    enclave_cmd_dispatcher_if.master bus
);
    localparam int PW = CNT_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, ARM, RUN} state_t;

    typedef struct packed {
        logic [1:0]            op;
        logic [ADDR_WIDTH-1:0] a1;
        logic [ADDR_WIDTH-1:0] a2;
        logic [ADDR_WIDTH-1:0] a3;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    entry_t                 mem [DEPTH];
    entry_t                 head;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic [TIMER_WIDTH-1:0] timer;
    logic [TAG_WIDTH-1:0]   cur_tag;
    state_t                 state;
    logic                   push;
    logic                   pop;
    logic                   tmo_hit;

    assign head    = mem[rd_ptr];
    assign push    = bus.cmd_valid && bus.cmd_ready;
    assign pop     = (state == IDLE) && (count != '0);
    assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                     (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
    assign bus.queue_count = count;

    // Next FIFO occupancy; simultaneous push and pop cancel out.
    always_comb begin
        cnt_nxt = count;
        if (push && !pop)
            cnt_nxt = count + 1'b1;
        else if (pop && !push)
            cnt_nxt = count - 1'b1;
    end

    // FIFO storage; flushing is done by resetting the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{op:  bus.cmd_opcode,
                             a1:  bus.cmd_op1_addr,
                             a2:  bus.cmd_op2_addr,
                             a3:  bus.cmd_out_addr,
                             tag: bus.cmd_tag};
    end

    // Issue FSM, FIFO pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                  <= IDLE;
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            count                  <= '0;
            timer                  <= '0;
            cur_tag                <= '0;
            bus.cmd_ready          <= 1'b1;
            bus.ctrl_config_en     <= 1'b0;
            bus.ctrl_opcode        <= '0;
            bus.ctrl_op1_base_addr <= '0;
            bus.ctrl_op2_base_addr <= '0;
            bus.ctrl_out_base_addr <= '0;
            bus.rsp_valid          <= 1'b0;
            bus.rsp_tag            <= '0;
            bus.rsp_timeout        <= 1'b0;
            bus.busy               <= 1'b0;
            bus.timeout_err        <= 1'b0;
        end else begin
            bus.rsp_valid   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            count         <= cnt_nxt;
            bus.cmd_ready <= (cnt_nxt != CNT_WIDTH'(DEPTH));
            bus.busy      <= (state != IDLE) || (count != '0);
            if (bus.clear_err)
                bus.timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        bus.ctrl_config_en     <= 1'b1;
                        bus.ctrl_opcode        <= head.op;
                        bus.ctrl_op1_base_addr <= head.a1;
                        bus.ctrl_op2_base_addr <= head.a2;
                        bus.ctrl_out_base_addr <= head.a3;
                        cur_tag                <= head.tag;
                        rd_ptr                 <= rd_ptr + 1'b1;
                        state                  <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.ctrl_config_en <= 1'b0;
                    state              <= ARM;
                end
                ARM: begin
                    timer <= '0;
                    state <= RUN;
                end
                RUN: begin
                    timer <= timer + 1'b1;
                    if (bus.ctrl_done) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_tag   <= cur_tag;
                        state         <= IDLE;
                    end else if (tmo_hit) begin
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_tag     <= cur_tag;
                        bus.rsp_timeout <= 1'b1;
                        bus.timeout_err <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enclave_cmd_dispatcher.sv
// Randomized and directed bench for enclave_cmd_dispatcher
// against a queue-based transaction model with a controller stub.
module tb_enclave_cmd_dispatcher;
    localparam int AW    = 10;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int TMW   = 16;
    localparam int TO    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    enclave_cmd_dispatcher_if #(
        .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)
    ) bus ();

    enclave_cmd_dispatcher #(
        .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH(DEPTH),
        .CNT_WIDTH(CW), .TIMER_WIDTH(TMW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] a3;
        logic [TW-1:0] tag;
        int            dly;
    } cmd_t;

    cmd_t q[$];
    cmd_t cur;
    cmd_t v_cmd;
    bit   inflight;
    int   age;
    bit   v_push;
    bit   v_clr;
    bit   acc;
    logic done_r;
    int   ctl_cnt;
    int   checks;
    int   failures;

    logic          e_cfg, e_rv, e_rto, e_busy, e_ready, e_err;
    logic [1:0]    e_op;
    logic [AW-1:0] e_a1, e_a2, e_a3;
    logic [TW-1:0] e_tag;
    int            e_cnt;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic cmd_t mk(logic [1:0] op, logic [AW-1:0] a1,
                                logic [AW-1:0] a2, logic [AW-1:0] a3,
                                logic [TW-1:0] tag, int dly);
        cmd_t c;
        c.op = op; c.a1 = a1; c.a2 = a2; c.a3 = a3;
        c.tag = tag; c.dly = dly;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        int d;
        d = int'($urandom_range(0, 14));
        return mk(2'($urandom), AW'($urandom), AW'($urandom),
                  AW'($urandom), TW'($urandom), (d > 12) ? -1 : d + 1);
    endfunction

    // One clock: drive inputs, predict, compare, advance controller stub.
    task automatic step();
        bit cfg_was;
        bit to_hit;
        cfg_was = e_cfg;
        to_hit  = 1'b0;
        bus.cmd_valid    = v_push;
        bus.cmd_opcode   = v_cmd.op;
        bus.cmd_op1_addr = v_cmd.a1;
        bus.cmd_op2_addr = v_cmd.a2;
        bus.cmd_out_addr = v_cmd.a3;
        bus.cmd_tag      = v_cmd.tag;
        bus.clear_err    = v_clr;
        bus.ctrl_done    = done_r;
        acc = v_push && e_ready;
        if (!rst_n) begin
            q.delete();
            inflight = 0; age = 0; acc = 0;
            e_cfg = 0; e_op = 0; e_a1 = 0; e_a2 = 0; e_a3 = 0;
            e_rv = 0; e_rto = 0; e_tag = 0; e_busy = 0;
            e_err = 0; e_cnt = 0; e_ready = 1;
        end else begin
            e_busy = inflight || (q.size() != 0);
            e_cfg = 0; e_rv = 0; e_rto = 0;
            if (inflight) begin
                age++;
                if (age >= 3 && done_r) begin
                    e_rv = 1; e_tag = cur.tag; inflight = 0;
                end else if (TO != 0 && age == 2 + TO) begin
                    e_rv = 1; e_rto = 1; e_tag = cur.tag;
                    inflight = 0; to_hit = 1;
                end
            end else if (q.size() != 0) begin
                cur = q.pop_front();
                inflight = 1; age = 0; e_cfg = 1;
                e_op = cur.op; e_a1 = cur.a1;
                e_a2 = cur.a2; e_a3 = cur.a3;
            end
            if (to_hit) e_err = 1;
            else if (v_clr) e_err = 0;
            if (acc) q.push_back(v_cmd);
            e_cnt   = q.size();
            e_ready = (q.size() != DEPTH);
        end
        @(posedge clk);
        #1;
        chk("config_en", 32'(bus.ctrl_config_en), 32'(e_cfg));
        chk("opcode", 32'(bus.ctrl_opcode), 32'(e_op));
        chk("op1_addr", 32'(bus.ctrl_op1_base_addr), 32'(e_a1));
        chk("op2_addr", 32'(bus.ctrl_op2_base_addr), 32'(e_a2));
        chk("out_addr", 32'(bus.ctrl_out_base_addr), 32'(e_a3));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
        chk("rsp_tag", 32'(bus.rsp_tag), 32'(e_tag));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e_rto));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("queue_count", 32'(bus.queue_count), 32'(e_cnt));
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(e_ready));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e_err));
        if (!rst_n) begin
            done_r = 0; ctl_cnt = 0;
        end else if (cfg_was) begin
            done_r  = 0;
            ctl_cnt = (cur.dly < 0) ? 0 : cur.dly;
        end else if (ctl_cnt > 0) begin
            ctl_cnt--;
            if (ctl_cnt == 0) done_r = 1;
        end
    endtask

    task automatic idle(int n);
        v_push = 0;
        repeat (n) step();
    endtask

    task automatic push_hold(cmd_t c);
        bit ok;
        ok = 0;
        v_push = 1; v_cmd = c;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            ok = acc;
        end
        v_push = 0;
        if (!ok) chk("push_stall", 32'd0, 32'd1);
    endtask

    task automatic drain(int max);
        int n;
        n = 0;
        v_push = 0;
        while ((inflight || q.size() != 0) && n < max) begin
            step();
            n++;
        end
        if (inflight || q.size() != 0) chk("drain_bound", 32'd0, 32'd1);
    endtask

    initial begin
        checks = 0; failures = 0;
        v_push = 0; v_clr = 0; acc = 0;
        v_cmd = mk(0, 0, 0, 0, 0, 1);
        cur = v_cmd;
        done_r = 0; ctl_cnt = 0; inflight = 0; age = 0;
        e_cfg = 0; e_op = 0; e_a1 = 0; e_a2 = 0; e_a3 = 0;
        e_rv = 0; e_rto = 0; e_tag = 0; e_busy = 0;
        e_err = 0; e_cnt = 0; e_ready = 1;

        rst_n = 0;
        idle(2);
        rst_n = 1;
        idle(1);

        push_hold(mk(2, 10'h010, 10'h040, 10'h080, 5, 6));
        drain(100);
        idle(2);

        for (int t = 1; t <= 3; t++)
            push_hold(mk(2'(t), AW'(t * 16), AW'(t * 32), AW'(t * 64), TW'(t), 6));
        drain(100);
        idle(2);

        for (int t = 0; t < 6; t++)
            push_hold(mk(2'(t), AW'(t + 100), AW'(t + 200), AW'(t + 300),
                         TW'(t + 8), -1));
        drain(300);
        idle(2);

        push_hold(mk(1, 10'h111, 10'h222, 10'h333, 9, 8));
        drain(100);
        v_clr = 1;
        idle(1);
        v_clr = 0;
        idle(2);

        v_clr = 1;
        push_hold(mk(3, 10'h0aa, 10'h0bb, 10'h0cc, 11, -1));
        drain(100);
        idle(2);
        v_clr = 0;

        for (int t = 0; t < 3; t++)
            push_hold(mk(0, AW'(t), AW'(t), AW'(t), TW'(t + 12), -1));
        v_push = 0;
        for (int i = 0; i < 20 && !(inflight && age >= 3); i++)
            step();
        rst_n = 0;
        idle(1);
        rst_n = 1;
        idle(1);
        push_hold(mk(2, 10'h3ff, 10'h155, 10'h2aa, 6, 3));
        drain(100);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            v_push = ($urandom_range(0, 1) == 1);
            v_cmd  = rnd_cmd();
            v_clr  = ($urandom_range(0, 19) == 0);
            step();
        end
        v_push = 0; v_clr = 0;
        drain(400);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
